coverfloat_vector_arbiter: RTL and testbench
============================================

Name: coverfloat_vector_arbiter

Overview:
- Shares the single coverfloat coverage-sampling channel between NUM_SRC independent test-vector sources, e.g. several DUT monitors or covervector readers.
- Round-robin arbitrates their valid/ready streams of packed coverfloat records and registers the winner in a one-entry output stage.
- Tags each output record with its source index and counts delivered transactions.
- Sits directly upstream of the logic that drives the coverfloat interface fields.

Parameters:
- NUM_SRC, 4, number of requesting sources (>=2).
- SRC_W, $clog2(NUM_SRC), width of the source-index tag.
- REC_W, 801, packed record width. Fields, MSB to LSB: op 32, rm 8, a 128, b 128, c 128, operandFmt 8, result 128, resultFmt 8, intermS 1, intermX 32, intermM 192, exceptionBits 8.
- CNT_W, 32, width of the delivered-transaction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new grants are issued; the output stage still drains.
- cnt_clear  input  1  synchronous clear of xact_count.
- req_valid  input  NUM_SRC  per-source record valid.
- req_ready  output  NUM_SRC  per-source accept, one-hot or zero.
- req_data  input  NUM_SRC*REC_W  per-source records; source i occupies bits [i*REC_W +: REC_W].
- out_valid  output  1  output record valid.
- out_ready  input  1  sampler accepts the output record.
- out_data  output  REC_W  registered winning record.
- out_src  output  SRC_W  index of the source that supplied out_data.
- xact_count  output  CNT_W  number of completed output handshakes, saturating.
- busy  output  1  out_valid OR any req_valid.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, xact_count=0, rr_ptr=NUM_SRC-1, so source 0 has first priority.
- Transfer condition: a transfer on either side is valid AND ready on the same rising edge.
- load_ok = enable AND (NOT out_valid OR out_ready). The output stage can take a new record in the same cycle the current one leaves, giving full throughput with no bubble.
- Grant (combinational):
  - Search req_valid starting at index (rr_ptr+1) mod NUM_SRC and wrapping upward.
  - The first set bit is the winner.
  - req_ready[winner]=load_ok; every other req_ready bit is 0.
  - No req_valid set -> req_ready all 0.
- req_ready never depends on req_data. req_ready may depend on req_valid and out_ready (combinational path).
- On a source transfer: out_data<=req_data[winner], out_src<=winner, out_valid<=1, rr_ptr<=winner.
- On an output transfer with no source transfer in the same cycle: out_valid<=0; out_data and out_src hold their last values.
- While out_valid=1 and out_ready=0: out_data and out_src are held stable; no grant is issued.
- Latency: 1 cycle from source transfer to out_valid.
- Sources must hold valid and data until ready. The arbiter never drops or duplicates a record.
- rr_ptr changes only on a source transfer. An idle cycle does not move priority.
- A single requester continuously valid is granted every cycle that load_ok holds.
- enable deasserted mid-stream: any record already in the output stage is still delivered; no further req_ready. Priority resumes from the saved rr_ptr when enable returns.
- xact_count:
  - Increments by 1 on each output transfer and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clear has priority over increment: a clear and a transfer in the same cycle yields 0.
- Reset mid-transfer: the output record is discarded (out_valid=0) and priority returns to source 0.
- No combinational path from out_ready to out_data or out_valid.

Test Plan:
- Reset, then all 4 sources valid continuously with out_ready=1 -> out_src sequence 0,1,2,3,0,1,...; one record per cycle; xact_count=8 after 8 cycles.
- Only source 2 valid with out_ready=1 -> req_ready[2]=1 every cycle; out_src=2; data matches in order with 1-cycle latency.
- out_valid=1 and out_ready held 0 for 5 cycles while sources 0 and 3 are valid -> out_data stable; req_ready=0; when out_ready rises, the next grant goes to the source after the last winner.
- Sources 1 and 3 valid, rr_ptr=3 -> source 1 is granted first; then source 3 with the source-1 record unchanged in the stream.
- Preload xact_count near saturation (force or CNT_W=4, 16 transfers) -> count stops at 15. Next cycle, cnt_clear=1 with a simultaneous transfer -> count=0.
- enable dropped while out_valid=1 -> that record is delivered, then out_valid=0 and req_ready=0. Re-enable -> arbitration resumes. Assert rst_n=0 mid-stream -> out_valid=0 immediately (asynchronously); after release, source 0 wins first.

Source files
------------

// File: rtl/coverfloat_vector_arbiter.sv
// -----------------------------------------------------------------------------
// coverfloat_vector_arbiter
//
// Shares the single coverfloat coverage-sampling channel between NUM_SRC
// independent test-vector sources. Each source offers packed coverfloat
// records over a valid/ready stream. A round-robin arbiter picks one winner.
// The winner is captured in a one-entry output register stage, tagged with its
// source index, and the number of delivered records is counted.
//
// Record layout (REC_W = 801), MSB to LSB:
//   op 32 | rm 8 | a 128 | b 128 | c 128 | operandFmt 8 | result 128 |
//   resultFmt 8 | intermS 1 | intermX 32 | intermM 192 | exceptionBits 8
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   low: no new grants; the output stage still drains
//   cnt_clear   in   synchronous clear of xact_count (wins over increment)
//   req_valid   in   [NUM_SRC]        per-source record valid
//   req_ready   out  [NUM_SRC]        per-source accept, one-hot or zero
//   req_data    in   [NUM_SRC*REC_W]  source i at bits [i*REC_W +: REC_W]
//   out_valid   out  output record valid (registered)
//   out_ready   in   sampler accepts the output record
//   out_data    out  [REC_W]  registered winning record
//   out_src     out  [SRC_W]  index of the source that supplied out_data
//   xact_count  out  [CNT_W]  completed output handshakes, saturating
//   busy        out  out_valid OR any req_valid
// -----------------------------------------------------------------------------
module coverfloat_vector_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int REC_W   = 801,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cnt_clear,
  input  logic [NUM_SRC-1:0]       req_valid,
  output logic [NUM_SRC-1:0]       req_ready,
  input  logic [NUM_SRC*REC_W-1:0] req_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REC_W-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  output logic [CNT_W-1:0]         xact_count,
  output logic                     busy
);

  // Pointer reset value: the search begins one past the pointer, so pointing
  // at the last source gives source 0 first priority.
  localparam logic [SRC_W-1:0] RR_RESET = SRC_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered state.
  logic               out_valid_q, out_valid_d;
  logic [REC_W-1:0]   out_data_q,  out_data_d;
  logic [SRC_W-1:0]   out_src_q,   out_src_d;
  logic [SRC_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]   xact_count_q, xact_count_d;

  // Combinational helpers.
  logic               load_ok_s;
  logic               grant_found_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [NUM_SRC-1:0] req_ready_s;
  logic               src_xfer_s;
  logic               out_xfer_s;
  logic [REC_W-1:0]   src_rec_s [NUM_SRC];
  logic [REC_W-1:0]   win_data_s;

  // The output stage can accept when empty or when its record leaves this
  // same cycle, so back-to-back records flow without a bubble.
  always_comb begin
    load_ok_s  = enable & (~out_valid_q | out_ready);
    out_xfer_s = out_valid_q & out_ready;
  end

  // Round-robin search: scan upward from rr_ptr+1 with wrap-around and take
  // the first valid source. The wrap is done explicitly so that a NUM_SRC
  // which is not a power of two still stays inside the source range.
  always_comb begin
    int sum_v;
    logic [SRC_W-1:0] idx_v;
    grant_found_s = 1'b0;
    grant_idx_s   = {SRC_W{1'b0}};
    sum_v         = 0;
    idx_v         = {SRC_W{1'b0}};
    for (int k = 1; k <= NUM_SRC; k++) begin
      sum_v = int'(rr_ptr_q) + k;
      idx_v = SRC_W'((sum_v >= NUM_SRC) ? (sum_v - NUM_SRC) : sum_v);
      if (!grant_found_s && req_valid[idx_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = idx_v;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accept strobe: only the winner sees ready, and only when the output stage
  // can take its record. Depends on req_valid/out_ready, never on req_data.
  always_comb begin
    req_ready_s = {NUM_SRC{1'b0}};
    if (grant_found_s && load_ok_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = {NUM_SRC{1'b0}};
    end
    src_xfer_s = grant_found_s & load_ok_s;
  end

  // Split the flat source bus into per-source records and select the winner.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_rec_s[k] = req_data[k*REC_W +: REC_W];
    end
    win_data_s = src_rec_s[grant_idx_s];
  end

  // Output stage and priority pointer next state. A new record overrides the
  // drain of the current one; otherwise data and tag hold their last values.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (src_xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data_s;
      out_src_d   = grant_idx_s;
      rr_ptr_d    = grant_idx_s;
    end else if (out_xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Delivered-transaction counter: clear wins, increment saturates.
  always_comb begin
    xact_count_d = xact_count_q;
    if (cnt_clear) begin
      xact_count_d = {CNT_W{1'b0}};
    end else if (out_xfer_s && (xact_count_q != CNT_MAX)) begin
      xact_count_d = xact_count_q + CNT_ONE;
    end else begin
      xact_count_d = xact_count_q;
    end
  end

  // State registers; reset discards any record held in the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= {REC_W{1'b0}};
      out_src_q    <= {SRC_W{1'b0}};
      rr_ptr_q     <= RR_RESET;
      xact_count_q <= {CNT_W{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      rr_ptr_q     <= rr_ptr_d;
      xact_count_q <= xact_count_d;
    end
  end

  // Output drive: everything toward the sampler comes straight from flops.
  always_comb begin
    req_ready  = req_ready_s;
    out_valid  = out_valid_q;
    out_data   = out_data_q;
    out_src    = out_src_q;
    xact_count = xact_count_q;
    busy       = out_valid_q | (|req_valid);
  end

endmodule

// File: tb/tb_coverfloat_vector_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for coverfloat_vector_arbiter (NUM_SRC=4, CNT_W=4 so saturation is
// reachable). A reference model predicts grants, output validity and the
// counter; accepted records are pushed to a scoreboard queue and popped when
// the sampler consumes them.
// -----------------------------------------------------------------------------
module tb_coverfloat_vector_arbiter;

  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int REC_W   = 801;
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef struct {
    logic [SRC_W-1:0] src;
    logic [REC_W-1:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     enable;
  logic                     cnt_clear;
  logic [NUM_SRC-1:0]       req_valid;
  logic [NUM_SRC-1:0]       req_ready;
  logic [NUM_SRC*REC_W-1:0] req_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [REC_W-1:0]         out_data;
  logic [SRC_W-1:0]         out_src;
  logic [CNT_W-1:0]         xact_count;
  logic                     busy;

  always #5 clk = ~clk;

  coverfloat_vector_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W),
    .REC_W   (REC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cnt_clear  (cnt_clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .xact_count (xact_count),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  exp_t             sb_q[$];
  logic [SRC_W-1:0] m_rr;
  logic             m_ov;
  logic [CNT_W-1:0] m_cnt;
  int               seq [NUM_SRC];

  // Unique, source- and sequence-dependent record content.
  function automatic logic [REC_W-1:0] make_rec(input int s, input int n);
    logic [REC_W-1:0] r;
    r = '0;
    for (int k = 0; k < 25; k++) begin
      r[k*32 +: 32] = {s[7:0], k[7:0], n[15:0]} ^ 32'hA5C3_5A3C;
    end
    r[REC_W-1] = n[0];
    return r;
  endfunction

  task automatic check(input string tag, input logic [REC_W-1:0] obs,
                       input logic [REC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int s = 0; s < NUM_SRC; s++) begin
      req_data[s*REC_W +: REC_W] = make_rec(s, seq[s]);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ov  = 1'b0;
    m_rr  = 2'd3;
    m_cnt = 4'd0;
  endtask

  // One clock cycle: called at the negedge with inputs applied. Checks the
  // DUT against the model before the edge, then advances the model.
  task automatic cycle(input string tag);
    logic               load_ok, found, src_x, out_x;
    logic [SRC_W-1:0]   w;
    logic [NUM_SRC-1:0] exp_rdy;
    exp_t               e;
    drive_data();
    #1;
    load_ok = enable && (!m_ov || out_ready);
    found   = 1'b0;
    w       = 2'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      int idx;
      idx = (int'(m_rr) + k) % NUM_SRC;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        w     = idx[SRC_W-1:0];
      end
    end
    exp_rdy = 4'b0000;
    if (found && load_ok) exp_rdy[w] = 1'b1;
    src_x = found && load_ok;
    out_x = m_ov && out_ready;
    check({tag, ".ready"}, REC_W'(req_ready), REC_W'(exp_rdy));
    check({tag, ".valid"}, REC_W'(out_valid), REC_W'(m_ov));
    check({tag, ".busy"},  REC_W'(busy), REC_W'(m_ov || (|req_valid)));
    check({tag, ".count"}, REC_W'(xact_count), REC_W'(m_cnt));
    if (m_ov && sb_q.size() > 0) begin
      check({tag, ".src"},  REC_W'(out_src), REC_W'(sb_q[0].src));
      check({tag, ".data"}, out_data, sb_q[0].data);
    end
    @(posedge clk);
    #1;
    if (out_x && sb_q.size() > 0) void'(sb_q.pop_front());
    if (src_x) begin
      e.src  = w;
      e.data = make_rec(w, seq[w]);
      sb_q.push_back(e);
      seq[w]++;
      m_rr = w;
    end
    m_ov = src_x ? 1'b1 : (out_x ? 1'b0 : m_ov);
    if (cnt_clear) m_cnt = 4'd0;
    else if (out_x && m_cnt != CNT_MAX) m_cnt = m_cnt + 4'd1;
    drive_data();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    cnt_clear = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    req_data  = '0;
    for (int s = 0; s < NUM_SRC; s++) seq[s] = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst.valid", REC_W'(out_valid), REC_W'(1'b0));
    check("rst.data",  out_data, '0);
    check("rst.src",   REC_W'(out_src), REC_W'(2'd0));
    check("rst.count", REC_W'(xact_count), REC_W'(4'd0));
    rst_n  = 1'b1;
    enable = 1'b1;
    cycle("idle");

    // All sources valid, sampler always ready: 0,1,2,3,0,... one per cycle.
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle("t1");
      check("t1.order", REC_W'(out_src), REC_W'(i % 4));
    end
    check("t1.count8", REC_W'(xact_count), REC_W'(4'd8));

    // Single requester granted every cycle.
    req_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      cycle("t2");
      check("t2.rdy", REC_W'(req_ready), REC_W'(4'b0100));
      check("t2.src", REC_W'(out_src), REC_W'(2'd2));
    end

    // Back-pressure with sources 0 and 3 valid; last winner was 2.
    req_valid = 4'b1001;
    cycle("t3a");
    check("t3a.src", REC_W'(out_src), REC_W'(2'd3));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("t3hold");
      check("t3hold.src", REC_W'(out_src), REC_W'(2'd3));
      check("t3hold.rdy", REC_W'(req_ready), REC_W'(4'b0000));
    end
    out_ready = 1'b1;
    #1;
    check("t3.next", REC_W'(req_ready), REC_W'(4'b0001));
    cycle("t3b");

    // Sources 1 and 3 with the pointer at 3: 1 first, then 3.
    req_valid = 4'b1000;
    cycle("t4pre");
    req_valid = 4'b1010;
    #1;
    check("t4.first", REC_W'(req_ready), REC_W'(4'b0010));
    cycle("t4a");
    #1;
    check("t4.second", REC_W'(req_ready), REC_W'(4'b1000));
    cycle("t4b");
    check("t4b.src", REC_W'(out_src), REC_W'(2'd3));
    req_valid = 4'b0000;
    cycle("t4drain");
    cycle("t4idle");

    // Counter saturation, then clear racing a transfer.
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) cycle("t5");
    check("t5.sat", REC_W'(xact_count), REC_W'(4'd15));
    cnt_clear = 1'b1;
    cycle("t5clr");
    cnt_clear = 1'b0;
    check("t5.clr", REC_W'(xact_count), REC_W'(4'd0));

    // Enable dropped with a record in the output stage.
    enable = 1'b0;
    #1;
    check("t6.nordy", REC_W'(req_ready), REC_W'(4'b0000));
    cycle("t6drain");
    check("t6.empty", REC_W'(out_valid), REC_W'(1'b0));
    cycle("t6idle");
    enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t6resume");
    check("t6.resumed", REC_W'(out_valid), REC_W'(1'b1));

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    check("t7.rst.valid", REC_W'(out_valid), REC_W'(1'b0));
    check("t7.rst.count", REC_W'(xact_count), REC_W'(4'd0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t7.first", REC_W'(req_ready), REC_W'(4'b0001));
    cycle("t7");
    check("t7.src", REC_W'(out_src), REC_W'(2'd0));
    cycle("t7b");
    req_valid = 4'b0000;
    cycle("t7drain");
    cycle("t7end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
